// File: rtl/time_pkg.sv
// Shared constants for the chained time counter: field indices, direction/mode
// encodings, default moduli and presets, and the field-width helper.
package time_pkg;

    localparam int unsigned NUM_FIELDS = 4;

    localparam logic [1:0] FLD_MSEC = 2'd0;
    localparam logic [1:0] FLD_SEC  = 2'd1;
    localparam logic [1:0] FLD_MIN  = 2'd2;
    localparam logic [1:0] FLD_HOUR = 2'd3;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam logic MODE_SW  = 1'b0;
    localparam logic MODE_CLK = 1'b1;

    localparam int unsigned DEF_MSEC_COUNT = 100;
    localparam int unsigned DEF_SEC_COUNT  = 60;
    localparam int unsigned DEF_MIN_COUNT  = 60;
    localparam int unsigned DEF_HOUR_COUNT = 24;

    localparam int unsigned DEF_INIT_MSEC = 0;
    localparam int unsigned DEF_INIT_SEC  = 0;
    localparam int unsigned DEF_INIT_MIN  = 0;
    localparam int unsigned DEF_INIT_HOUR = 12;

    // Bits needed to hold 0..mod-1; never narrower than one bit.
    function automatic int unsigned fld_width(input int unsigned mod);
        return (mod > 1) ? $clog2(mod) : 1;
    endfunction

endpackage

// File: rtl/mod_stage.sv
// One modulo field of the time chain: preset load, clear, up/down count with
// carry/borrow out, and an isolated +1 edit that never carries.
module mod_stage
    import time_pkg::*;
#(
    parameter int unsigned MOD  = 10,
    parameter int unsigned INIT = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      dir,
    input  logic                      clr,
    input  logic                      load,
    input  logic                      inc,
    output logic [fld_width(MOD)-1:0] value,
    output logic                      carry_out
);

    localparam int unsigned W = fld_width(MOD);
    localparam logic [W-1:0] LAST   = W'(MOD - 1);
    localparam logic [W-1:0] INIT_V = W'(INIT);

    logic         at_top;
    logic         at_zero;
    logic [W-1:0] up_val;
    logic [W-1:0] dn_val;

    assign at_top  = (value == LAST);
    assign at_zero = (value == '0);
    assign up_val  = at_top  ? '0   : value + W'(1);
    assign dn_val  = at_zero ? LAST : value - W'(1);

    // Carry on up-wrap, borrow on down-wrap; only meaningful while counting.
    assign carry_out = en & ((dir == DIR_DOWN) ? at_zero : at_top);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= INIT_V;
        end else if (clr) begin
            value <= '0;
        end else if (en) begin
            value <= (dir == DIR_DOWN) ? dn_val : up_val;
        end else if (inc) begin
            value <= up_val;
        end
    end

endmodule

// File: rtl/time_counter_chain.sv
// Centisecond/second/minute/hour time core: four chained modulo stages with
// run/stop, up/down, stopwatch/clock preset, clear and per-field edit.
module time_counter_chain
    import time_pkg::*;
#(
    parameter int unsigned MSEC_COUNT = DEF_MSEC_COUNT,
    parameter int unsigned SEC_COUNT  = DEF_SEC_COUNT,
    parameter int unsigned MIN_COUNT  = DEF_MIN_COUNT,
    parameter int unsigned HOUR_COUNT = DEF_HOUR_COUNT,
    parameter int unsigned INIT_MSEC  = DEF_INIT_MSEC,
    parameter int unsigned INIT_SEC   = DEF_INIT_SEC,
    parameter int unsigned INIT_MIN   = DEF_INIT_MIN,
    parameter int unsigned INIT_HOUR  = DEF_INIT_HOUR
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             i_tick,
    input  logic                             i_run,
    input  logic                             i_clear,
    input  logic                             i_dir,
    input  logic                             i_mode,
    input  logic [1:0]                       i_edit_sel,
    input  logic                             i_edit_inc,
    output logic [fld_width(MSEC_COUNT)-1:0] o_msec,
    output logic [fld_width(SEC_COUNT)-1:0]  o_sec,
    output logic [fld_width(MIN_COUNT)-1:0]  o_min,
    output logic [fld_width(HOUR_COUNT)-1:0] o_hour,
    output logic                             o_wrap,
    output logic                             o_zero
);

    logic                  load_pending;
    logic                  mode_q;
    logic                  all_zero;
    logic                  sw_hold;
    logic                  cnt_en;
    logic                  edit_en;
    logic                  stage_load;
    logic                  stage_clr;
    logic [NUM_FIELDS-1:0] carry;
    logic [NUM_FIELDS-1:0] stage_en;
    logic [NUM_FIELDS-1:0] stage_inc;

    assign all_zero = (o_msec == '0) && (o_sec == '0) && (o_min == '0) && (o_hour == '0);
    assign o_zero   = all_zero;

    // Stopwatch counting down parks at zero instead of borrowing into 23:59.
    assign sw_hold = (i_dir == DIR_DOWN) && (i_mode == MODE_SW) && all_zero;

    assign cnt_en  = !load_pending && !i_clear && i_run && i_tick && !sw_hold;
    assign edit_en = !load_pending && !i_clear && !i_run && i_edit_inc;

    // A preset in stopwatch mode is just a clear to zero.
    assign stage_load = load_pending && (i_mode == MODE_CLK);
    assign stage_clr  = (load_pending && (i_mode == MODE_SW)) || (!load_pending && i_clear);

    assign stage_en[0] = cnt_en;
    assign stage_en[1] = carry[0] & cnt_en;
    assign stage_en[2] = carry[1] & cnt_en;
    assign stage_en[3] = carry[2] & cnt_en;

    assign stage_inc[0] = edit_en && (i_edit_sel == FLD_MSEC);
    assign stage_inc[1] = edit_en && (i_edit_sel == FLD_SEC);
    assign stage_inc[2] = edit_en && (i_edit_sel == FLD_MIN);
    assign stage_inc[3] = edit_en && (i_edit_sel == FLD_HOUR);

    // A mode change requests a preset for the following cycle; a preset that is
    // already being applied samples the current mode, so it absorbs the change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_pending <= 1'b1;
            mode_q       <= MODE_SW;
            o_wrap       <= 1'b0;
        end else begin
            load_pending <= load_pending ? 1'b0 : (i_mode != mode_q);
            mode_q       <= i_mode;
            o_wrap       <= carry[NUM_FIELDS-1];
        end
    end

    mod_stage #(.MOD(MSEC_COUNT), .INIT(INIT_MSEC)) u_msec (
        .clk(clk), .reset(reset), .en(stage_en[0]), .dir(i_dir), .clr(stage_clr),
        .load(stage_load), .inc(stage_inc[0]), .value(o_msec), .carry_out(carry[0])
    );

    mod_stage #(.MOD(SEC_COUNT), .INIT(INIT_SEC)) u_sec (
        .clk(clk), .reset(reset), .en(stage_en[1]), .dir(i_dir), .clr(stage_clr),
        .load(stage_load), .inc(stage_inc[1]), .value(o_sec), .carry_out(carry[1])
    );

    mod_stage #(.MOD(MIN_COUNT), .INIT(INIT_MIN)) u_min (
        .clk(clk), .reset(reset), .en(stage_en[2]), .dir(i_dir), .clr(stage_clr),
        .load(stage_load), .inc(stage_inc[2]), .value(o_min), .carry_out(carry[2])
    );

    mod_stage #(.MOD(HOUR_COUNT), .INIT(INIT_HOUR)) u_hour (
        .clk(clk), .reset(reset), .en(stage_en[3]), .dir(i_dir), .clr(stage_clr),
        .load(stage_load), .inc(stage_inc[3]), .value(o_hour), .carry_out(carry[3])
    );

endmodule

// File: tb/tb_time_counter_chain.sv
// Scoreboard bench for time_counter_chain: directed stimulus queues expected
// field values per cycle, an independent monitor compares them on the falling edge.
module tb_time_counter_chain;

    logic       clk;
    logic       reset;
    logic       i_tick;
    logic       i_run;
    logic       i_clear;
    logic       i_dir;
    logic       i_mode;
    logic [1:0] i_edit_sel;
    logic       i_edit_inc;
    logic [6:0] o_msec;
    logic [5:0] o_sec;
    logic [5:0] o_min;
    logic [4:0] o_hour;
    logic       o_wrap;
    logic       o_zero;

    time_counter_chain dut (
        .clk(clk), .reset(reset), .i_tick(i_tick), .i_run(i_run), .i_clear(i_clear),
        .i_dir(i_dir), .i_mode(i_mode), .i_edit_sel(i_edit_sel), .i_edit_inc(i_edit_inc),
        .o_msec(o_msec), .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour),
        .o_wrap(o_wrap), .o_zero(o_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        string      name;
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic [6:0] ms;
        logic       w;
        logic       z;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Queue an expectation to be checked at the falling edge `off` cycles ahead.
    task automatic expect_at(input string nm, input int h, input int m, input int s,
                             input int ms, input logic w, input int off);
        exp_t e;
        e.cyc  = cyc + off;
        e.name = nm;
        e.h    = 5'(h);
        e.m    = 6'(m);
        e.s    = 6'(s);
        e.ms   = 7'(ms);
        e.w    = w;
        e.z    = (h == 0) && (m == 0) && (s == 0) && (ms == 0);
        exp_q.push_back(e);
    endtask

    task automatic expect_next(input string nm, input int h, input int m, input int s,
                               input int ms, input logic w);
        expect_at(nm, h, m, s, ms, w, 1);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Clear, then walk each field up with edit pulses while stopped.
    task automatic set_time(input int h, input int m, input int s, input int ms);
        i_run   = 1'b0;
        i_tick  = 1'b0;
        i_clear = 1'b1;
        step();
        i_clear    = 1'b0;
        i_edit_inc = 1'b1;
        i_edit_sel = 2'd0;
        repeat (ms) step();
        i_edit_sel = 2'd1;
        repeat (s) step();
        i_edit_sel = 2'd2;
        repeat (m) step();
        i_edit_sel = 2'd3;
        repeat (h) step();
        i_edit_inc = 1'b0;
    endtask

    // Monitor: pops every expectation due this cycle and compares.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                total++;
                if (e.cyc != cyc ||
                    {o_hour, o_min, o_sec, o_msec, o_wrap, o_zero} !==
                    {e.h, e.m, e.s, e.ms, e.w, e.z}) begin
                    bad++;
                    $display("FAIL %s: got %0d:%0d:%0d:%0d wrap=%0b zero=%0b, want %0d:%0d:%0d:%0d wrap=%0b zero=%0b (cyc %0d/%0d)",
                             e.name, o_hour, o_min, o_sec, o_msec, o_wrap, o_zero,
                             e.h, e.m, e.s, e.ms, e.w, e.z, cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        i_tick     = 1'b0;
        i_run      = 1'b0;
        i_clear    = 1'b0;
        i_dir      = 1'b0;
        i_mode     = 1'b0;
        i_edit_sel = 2'd0;
        i_edit_inc = 1'b0;
        step();

        // Reset and preset load in both modes
        expect_next("rst_sw", 0, 0, 0, 0, 0);
        step();
        reset = 1'b0;
        expect_next("load_sw", 0, 0, 0, 0, 0);
        step();
        reset  = 1'b1;
        i_mode = 1'b1;
        expect_next("rst_clk", 0, 0, 0, 0, 0);
        step();
        reset = 1'b0;
        expect_next("load_clk", 12, 0, 0, 0, 0);
        step();
        expect_next("load_once", 12, 0, 0, 0, 0);
        step();

        // Up-count carry into minutes and full-chain wrap
        set_time(0, 0, 59, 99);
        i_run  = 1'b1;
        i_tick = 1'b1;
        expect_next("carry_min", 0, 1, 0, 0, 0);
        step();
        set_time(23, 59, 59, 99);
        i_run  = 1'b1;
        i_tick = 1'b1;
        expect_next("wrap_up", 0, 0, 0, 0, 1);
        step();
        i_tick = 1'b0;
        expect_next("wrap_up_1cyc", 0, 0, 0, 0, 0);
        step();

        // Down-count in clock mode borrows through to 23:59:59:99
        i_dir  = 1'b1;
        i_tick = 1'b1;
        expect_next("wrap_dn_clk", 23, 59, 59, 99, 1);
        step();
        i_tick = 1'b0;
        expect_next("wrap_dn_1cyc", 23, 59, 59, 99, 0);
        step();

        // Mode change: preset applied one cycle after the edge is seen
        i_mode = 1'b0;
        expect_next("mode_edge", 23, 59, 59, 99, 0);
        step();
        expect_next("mode_load_sw", 0, 0, 0, 0, 0);
        step();

        // Stopwatch down-count parks at zero
        i_tick = 1'b1;
        repeat (5) begin
            expect_next("sw_dn_hold", 0, 0, 0, 0, 0);
            step();
        end
        i_tick = 1'b0;

        // Edit wraps the minute field without touching hours
        set_time(5, 59, 0, 0);
        i_edit_sel = 2'd2;
        i_edit_inc = 1'b1;
        expect_next("edit_wrap", 5, 0, 0, 0, 0);
        step();

        // Tick wins over a simultaneous edit
        i_run  = 1'b1;
        i_tick = 1'b1;
        i_dir  = 1'b0;
        expect_next("tick_over_edit", 5, 0, 0, 1, 0);
        step();
        i_tick     = 1'b0;
        i_edit_inc = 1'b0;

        // Clear wins over a simultaneous tick
        set_time(0, 0, 10, 5);
        i_run   = 1'b1;
        i_tick  = 1'b1;
        i_clear = 1'b1;
        expect_next("clear_over_tick", 0, 0, 0, 0, 0);
        step();
        i_clear = 1'b0;
        i_tick  = 1'b0;

        // Asynchronous reset mid-count, then reload in clock mode
        set_time(3, 25, 41, 17);
        i_run  = 1'b1;
        i_tick = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        expect_at("async_rst", 0, 0, 0, 0, 0, 0);
        step();
        i_mode = 1'b1;
        step();
        reset = 1'b0;
        expect_next("reload_clk", 12, 0, 0, 0, 0);
        step();
        expect_next("count_after_load", 12, 0, 0, 1, 0);
        step();
        i_tick = 1'b0;
        i_run  = 1'b0;

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
